// File: rtl/ste_dma_snd_fifo_player.sv
// DMA sound playback engine: fetches 16-bit words from 64-bit RAM in granted slots, buffers them
// in a FIFO and plays them out as stereo words or mono bytes at 6.25/12.5/25/50 kHz.
// Latency: registered outputs one clk32 after the causing event; mem_read is combinational.
// Backpressure: no fetch request while the FIFO is full; empty FIFO on a sample tick holds audio.
// Ports:
//   clk32, reset         clock, synchronous active-high reset
//   start/stop/loop      playback control (pulses / level)
//   rate, mono           sample rate select, mono-byte vs stereo-word format
//   snd_bas/snd_end      frame start address / address after the last word
//   slot/slot_done       memory slot available / end-of-slot strobe with mem_data valid
//   mem_read/mem_addr    fetch request and word address
//   mem_data             64-bit RAM line, word k at bits [16k+15:16k]
//   snd_adr              current frame address counter
//   audio_l/audio_r      unsigned 8-bit samples
//   active/frame_end     frame running / end-of-frame pulse
//   fifo_level/underflow buffered word count / saturating empty-tick count while running
module ste_dma_snd_fifo_player #(
  parameter int FIFO_AW  = 3,
  parameter int BASE_DIV = 640,
  parameter int UF_W     = 12
) (
  input  logic               clk32,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               loop,
  input  logic [1:0]         rate,
  input  logic               mono,
  input  logic [22:0]        snd_bas,
  input  logic [22:0]        snd_end,
  input  logic               slot,
  input  logic               slot_done,
  output logic               mem_read,
  output logic [22:0]        mem_addr,
  input  logic [63:0]        mem_data,
  output logic [22:0]        snd_adr,
  output logic [7:0]         audio_l,
  output logic [7:0]         audio_r,
  output logic               active,
  output logic               frame_end,
  output logic [FIFO_AW:0]   fifo_level,
  output logic [UF_W-1:0]    underflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int DIV_W = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
  localparam logic [FIFO_AW:0] PTR_ONE = 1;
  localparam logic [UF_W-1:0]  UF_ONE  = 1;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [2:0]         cnt3_q, cnt3_d;
  logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0]   rd_ptr_q, rd_ptr_d;
  logic [22:0]        snd_adr_q, snd_adr_d;
  logic [22:0]        end_q, end_d;
  logic               byte_q, byte_d;
  logic [7:0]         audio_l_q, audio_l_d;
  logic [7:0]         audio_r_q, audio_r_d;
  logic               active_q, active_d;
  logic               frame_end_q, frame_end_d;
  logic [UF_W-1:0]    uf_q, uf_d;
  logic [15:0]        fifo_mem_q [DEPTH];

  logic               running, at_end, empty, full;
  logic               base_tick, sample_tick, fifo_we;
  logic [2:0]         rate_mask;
  logic [15:0]        sel_word, rd_word;
  logic [7:0]         mono_byte;

  assign running = (state_q == ST_RUN);
  assign at_end  = (snd_adr_q == end_q);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  // Full when the pointers alias the same slot but are one lap apart.
  assign full    = (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]) &&
                   (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]);

  assign base_tick = (div_q == DIV_W'(BASE_DIV - 1));

  // Slower rates use fewer base ticks: require the low (3-rate) bits of cnt3 to be zero.
  always_comb begin
    case (rate)
      2'b00:   rate_mask = 3'b111;
      2'b01:   rate_mask = 3'b011;
      2'b10:   rate_mask = 3'b001;
      default: rate_mask = 3'b000;
    endcase
  end
  assign sample_tick = base_tick && ((cnt3_q & rate_mask) == 3'b000);

  always_comb begin
    case (snd_adr_q[1:0])
      2'd0:    sel_word = mem_data[15:0];
      2'd1:    sel_word = mem_data[31:16];
      2'd2:    sel_word = mem_data[47:32];
      default: sel_word = mem_data[63:48];
    endcase
  end

  assign rd_word   = fifo_mem_q[rd_ptr_q[FIFO_AW-1:0]];
  assign mono_byte = byte_q ? rd_word[7:0] : rd_word[15:8];

  assign mem_read = running && slot && !full && !at_end;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    snd_adr_d   = snd_adr_q;
    end_d       = end_q;
    byte_d      = byte_q;
    audio_l_d   = audio_l_q;
    audio_r_d   = audio_r_q;
    uf_d        = uf_q;
    fifo_we     = 1'b0;
    frame_end_d = 1'b0;
    active_d    = running && !at_end;
    div_d       = base_tick ? '0 : div_q + DIV_W'(1);
    cnt3_d      = base_tick ? cnt3_q + 3'd1 : cnt3_q;

    if (stop) begin
      // Abort: drop buffered words and return the outputs to midscale.
      state_d   = ST_IDLE;
      rd_ptr_d  = wr_ptr_q;
      byte_d    = 1'b0;
      audio_l_d = 8'h80;
      audio_r_d = 8'h80;
    end else begin
      if (sample_tick) begin
        if (!empty) begin
          if (!mono) begin
            audio_l_d = rd_word[15:8] + 8'h80;
            audio_r_d = rd_word[7:0] + 8'h80;
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
          end else begin
            audio_l_d = mono_byte + 8'h80;
            audio_r_d = mono_byte + 8'h80;
            byte_d    = !byte_q;
            if (byte_q) begin
              rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
          end
        end else if (running) begin
          if (uf_q != '1) begin
            uf_d = uf_q + UF_ONE;
          end
        end else begin
          byte_d = 1'b0;
        end
      end

      if (!running && start) begin
        state_d   = ST_RUN;
        snd_adr_d = snd_bas;
        end_d     = snd_end;
        byte_d    = 1'b0;
      end else if (running && slot_done && !full) begin
        if (!at_end) begin
          fifo_we   = 1'b1;
          wr_ptr_d  = wr_ptr_q + PTR_ONE;
          snd_adr_d = snd_adr_q + 23'd1;
        end else begin
          // The slot at frame end is consumed without fetching.
          frame_end_d = 1'b1;
          if (loop) begin
            snd_adr_d = snd_bas;
            end_d     = snd_end;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk32) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      cnt3_q      <= 3'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      snd_adr_q   <= 23'd0;
      end_q       <= 23'd0;
      byte_q      <= 1'b0;
      audio_l_q   <= 8'h80;
      audio_r_q   <= 8'h80;
      active_q    <= 1'b0;
      frame_end_q <= 1'b0;
      uf_q        <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      cnt3_q      <= cnt3_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      snd_adr_q   <= snd_adr_d;
      end_q       <= end_d;
      byte_q      <= byte_d;
      audio_l_q   <= audio_l_d;
      audio_r_q   <= audio_r_d;
      active_q    <= active_d;
      frame_end_q <= frame_end_d;
      uf_q        <= uf_d;
    end
  end

  // Storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge clk32) begin
    if (fifo_we) begin
      fifo_mem_q[wr_ptr_q[FIFO_AW-1:0]] <= sel_word;
    end
  end

  assign mem_addr   = snd_adr_q;
  assign snd_adr    = snd_adr_q;
  assign audio_l    = audio_l_q;
  assign audio_r    = audio_r_q;
  assign active     = active_q;
  assign frame_end  = frame_end_q;
  assign fifo_level = wr_ptr_q - rd_ptr_q;
  assign underflow  = uf_q;

endmodule

// File: tb/tb_ste_dma_snd_fifo_player.sv
module tb_ste_dma_snd_fifo_player;
  localparam int FAW   = 3;
  localparam int BD    = 4;
  localparam int UFW   = 12;
  localparam int DEPTH = 1 << FAW;

  logic clk32 = 1'b0;
  logic reset, start, stop, loop, mono, slot, slot_done;
  logic [1:0]  rate;
  logic [22:0] snd_bas, snd_end;
  logic [63:0] mem_data;
  logic        mem_read, active, frame_end;
  logic [22:0] mem_addr, snd_adr;
  logic [7:0]  audio_l, audio_r;
  logic [FAW:0] fifo_level;
  logic [UFW-1:0] underflow;

  always #5 clk32 = ~clk32;

  ste_dma_snd_fifo_player #(.FIFO_AW(FAW), .BASE_DIV(BD), .UF_W(UFW)) dut (
    .clk32(clk32), .reset(reset), .start(start), .stop(stop), .loop(loop), .rate(rate),
    .mono(mono), .snd_bas(snd_bas), .snd_end(snd_end), .slot(slot), .slot_done(slot_done),
    .mem_read(mem_read), .mem_addr(mem_addr), .mem_data(mem_data), .snd_adr(snd_adr),
    .audio_l(audio_l), .audio_r(audio_r), .active(active), .frame_end(frame_end),
    .fifo_level(fifo_level), .underflow(underflow)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // RAM image: explicit words where a test needs them, a hash elsewhere.
  logic [15:0] ram [int];

  function automatic logic [15:0] ram_word(input logic [22:0] a);
    if (ram.exists(int'(a))) return ram[int'(a)];
    return 16'(a * 23'd40503) ^ 16'h5A3C;
  endfunction

  function automatic logic [63:0] ram_line(input logic [22:0] a);
    logic [63:0] l;
    for (int k = 0; k < 4; k++) l[16*k +: 16] = ram_word({a[22:2], 2'(k)});
    return l;
  endfunction

  // Behavioural model: a word queue plus the playback rules.
  bit          m_run, m_byte, m_fe, m_act, m_played;
  logic [22:0] m_adr, m_end;
  logic [15:0] m_q [$];
  logic [7:0]  m_l, m_r;
  int          m_uf, m_c;

  int          g_cyc, fe_cnt;
  logic [7:0]  aud_l_log [$];
  logic [7:0]  aud_r_log [$];
  int          play_cyc [$];
  logic [22:0] adr_log [$];

  task automatic m_step();
    bit full, empty, smp;
    int k;
    logic [15:0] w;
    m_played = 0;
    full  = (m_q.size() == DEPTH);
    empty = (m_q.size() == 0);
    k     = m_c / BD;
    smp   = ((m_c % BD) == BD - 1) && ((k % (8 >> rate)) == 0);
    m_act = m_run && (m_adr != m_end);
    m_fe  = 0;
    if (reset) begin
      m_run = 0; m_byte = 0; m_act = 0; m_adr = 0; m_end = 0; m_q.delete();
      m_l = 8'h80; m_r = 8'h80; m_uf = 0; m_c = 0;
      return;
    end
    m_c++;
    if (stop) begin
      m_q.delete(); m_byte = 0; m_l = 8'h80; m_r = 8'h80; m_run = 0;
    end else begin
      if (smp) begin
        if (!empty) begin
          w = m_q[0];
          m_played = 1;
          if (!mono) begin
            m_l = w[15:8] + 8'd128;
            m_r = w[7:0] + 8'd128;
            void'(m_q.pop_front());
          end else begin
            m_l = (m_byte ? w[7:0] : w[15:8]) + 8'd128;
            m_r = m_l;
            if (m_byte) void'(m_q.pop_front());
            m_byte = !m_byte;
          end
        end else if (m_run) begin
          if (m_uf < (1 << UFW) - 1) m_uf++;
        end else begin
          m_byte = 0;
        end
      end
      if (!m_run && start) begin
        m_run = 1; m_adr = snd_bas; m_end = snd_end; m_byte = 0;
      end else if (m_run && slot_done && !full) begin
        if (m_adr != m_end) begin
          m_q.push_back(ram_word(m_adr));
          m_adr = m_adr + 23'd1;
        end else begin
          m_fe = 1;
          if (loop) begin m_adr = snd_bas; m_end = snd_end; end
          else m_run = 0;
        end
      end
    end
  endtask

  // One clock: inputs already driven; check combinational and registered outputs vs model.
  task automatic step();
    mem_data = ram_line(m_adr);
    #1;
    if (!reset) begin
      check("mem_read", mem_read, m_run && slot && (m_q.size() < DEPTH) && (m_adr != m_end));
      check("mem_addr", mem_addr, m_adr);
    end
    m_step();
    @(posedge clk32);
    #1;
    g_cyc++;
    check("audio_l", audio_l, m_l);
    check("audio_r", audio_r, m_r);
    check("fifo_level", fifo_level, m_q.size());
    check("frame_end", frame_end, m_fe);
    check("active", active, m_act);
    check("underflow", underflow, m_uf);
    check("snd_adr", snd_adr, m_adr);
    if (frame_end) fe_cnt++;
    if (m_played) begin
      aud_l_log.push_back(audio_l);
      aud_r_log.push_back(audio_r);
      play_cyc.push_back(g_cyc);
    end
    if (adr_log.size() == 0 || adr_log[$] != snd_adr) adr_log.push_back(snd_adr);
    reset = 0; start = 0; stop = 0; slot_done = 0;
  endtask

  task automatic clear_logs();
    aud_l_log.delete(); aud_r_log.delete(); play_cyc.delete(); adr_log.delete(); fe_cnt = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1; start = 0; stop = 0; loop = 0; mono = 0; slot = 0; slot_done = 0;
    rate = 2'b11; snd_bas = 0; snd_end = 0; mem_data = 0; g_cyc = 0; m_c = 0;
    step();
    reset = 1;
    step();
    check("rst_audio_l", audio_l, 8'h80);
    check("rst_audio_r", audio_r, 8'h80);
    check("rst_level", fifo_level, 0);
    check("rst_underflow", underflow, 0);
    check("rst_active", active, 0);

    // Stereo 50k, four-word frame, no loop.
    ram[32'h100] = 16'h7F80; ram[32'h101] = 16'h0001;
    ram[32'h102] = 16'h1234; ram[32'h103] = 16'hFEDC;
    rate = 2'b11; mono = 0; loop = 0; snd_bas = 23'h100; snd_end = 23'h104;
    clear_logs();
    start = 1; step();
    for (int i = 0; i < 80; i++) begin
      slot = 1; slot_done = (i % 2 == 0); step();
    end
    check("st_frame_end_cnt", fe_cnt, 1);
    check("st_plays", aud_l_log.size(), 4);
    if (aud_l_log.size() >= 2) begin
      check("st_first_l", aud_l_log[0], 8'hFF);
      check("st_first_r", aud_r_log[0], 8'h00);
      check("st_second_l", aud_l_log[1], 8'h80);
      check("st_second_r", aud_r_log[1], 8'h81);
    end
    check("st_end_adr", snd_adr, 23'h104);
    check("st_idle_mem_read", mem_read, 0);
    check("st_drained", fifo_level, 0);

    // Mono 6.25k, two words -> four bytes at 8 base ticks apart.
    ram[32'h300] = 16'h0102; ram[32'h301] = 16'h0304;
    rate = 2'b00; mono = 1; snd_bas = 23'h300; snd_end = 23'h302;
    clear_logs();
    start = 1; step();
    for (int i = 0; i < 200; i++) begin
      slot = 1; slot_done = (i % 2 == 0); step();
    end
    check("mono_plays", aud_l_log.size(), 4);
    for (int i = 0; i < 4 && i < aud_l_log.size(); i++) begin
      check("mono_l", aud_l_log[i], 8'h81 + 8'(i));
      check("mono_r", aud_r_log[i], 8'h81 + 8'(i));
    end
    for (int i = 0; i + 1 < play_cyc.size(); i++)
      check("mono_interval", play_cyc[i+1] - play_cyc[i], 8 * BD);

    // Fill to full with a slot every cycle before any pop.
    snd_bas = 23'h400; snd_end = 23'h420;
    for (int i = 0; i < 64 && (m_c % (8 * BD)) != 4; i++) step();
    start = 1; step();
    for (int i = 0; i < 12; i++) begin
      slot = 1; slot_done = 1; step();
    end
    check("full_level", fifo_level, DEPTH);
    check("full_mem_read", mem_read, 0);
    check("full_adr", snd_adr, 23'h408);
    for (int i = 0; i < 150; i++) begin
      slot = 1; slot_done = 1; step();
    end
    stop = 1; step();
    check("full_stop_level", fifo_level, 0);

    // Looping two-word frame.
    rate = 2'b11; mono = 0; loop = 1; snd_bas = 23'h200; snd_end = 23'h202;
    clear_logs();
    start = 1; step();
    for (int i = 0; i < 60; i++) begin
      slot = 1; slot_done = (i % 3 == 0); step();
    end
    check("loop_fe_cnt", fe_cnt, 6);
    if (adr_log.size() >= 4) begin
      check("loop_adr0", adr_log[0], 23'h200);
      check("loop_adr1", adr_log[1], 23'h201);
      check("loop_adr2", adr_log[2], 23'h202);
      check("loop_adr3", adr_log[3], 23'h200);
    end else check("loop_adr_log", adr_log.size(), 4);
    loop = 0; stop = 1; step();

    // Stop mid-frame with five words buffered; then start+stop together.
    rate = 2'b00; snd_bas = 23'h500; snd_end = 23'h510; slot = 1;
    for (int i = 0; i < 64 && (m_c % (8 * BD)) != 4; i++) step();
    start = 1; step();
    for (int i = 0; i < 5; i++) begin
      slot_done = 1; step();
    end
    check("stop_pre_level", fifo_level, 5);
    check("stop_pre_active", active, 1);
    stop = 1; step();
    check("stop_level", fifo_level, 0);
    check("stop_audio_l", audio_l, 8'h80);
    check("stop_audio_r", audio_r, 8'h80);
    check("stop_mem_read", mem_read, 0);
    step();
    check("stop_active", active, 0);
    start = 1; stop = 1; step();
    check("startstop_mem_read", mem_read, 0);
    step();
    check("startstop_active", active, 0);

    // Underflow saturation with no slots at 50k, then reset mid-RUN.
    reset = 1; step();
    rate = 2'b11; slot = 0; snd_bas = 23'h600; snd_end = 23'h610;
    start = 1; step();
    for (int i = 0; i < 4095 * BD + 40; i++) step();
    check("uf_saturated", underflow, 12'hFFF);
    reset = 1; step();
    check("rst2_underflow", underflow, 0);
    check("rst2_adr", snd_adr, 0);
    check("rst2_active", active, 0);
    check("rst2_audio_l", audio_l, 8'h80);
    slot = 1; #1;
    check("rst2_mem_read", mem_read, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 6000; i++) begin
      slot = 1'($urandom);
      slot_done = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 39) == 0) begin
        start = 1;
        rate = 2'($urandom);
        mono = 1'($urandom);
        loop = ($urandom_range(0, 3) == 0);
        snd_bas = ($urandom_range(0, 4) == 0) ? 23'h7FFFFD : 23'h700 + 23'($urandom_range(0, 60));
        snd_end = snd_bas + 23'($urandom_range(0, 6));
      end
      if ($urandom_range(0, 149) == 0) stop = 1;
      if ($urandom_range(0, 2999) == 0) reset = 1;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
